// File: rtl/pipe_frame_packer.sv
// Packs four 32-bit PipeIn words into 128-bit frames and queues them in a
// small FIFO; frames that find the FIFO full are dropped and counted.
module pipe_frame_packer #(
  parameter int FRAME_WORDS = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        okClk,
  input  logic                        rst,
  input  logic [31:0]                 pipe_in_data,
  input  logic                        pipe_in_valid,
  input  logic                        flush,
  input  logic                        clear_ovf,
  output logic [127:0]                frame_data,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_C  = FW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [FW-1:0] CNT_ONE  = FW'(1);
  localparam logic [1:0]    LAST_IDX = 2'(FRAME_WORDS - 1);

  logic [1:0]   idx_q, idx_d;
  logic [95:0]  asm_q, asm_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic [15:0]  drop_q, drop_d;
  logic [127:0] mem_q [FIFO_DEPTH];

  logic [127:0] frame_s;
  logic         push_s, pop_s, accept_s, drop_s;

  // A full FIFO still takes a frame when the head leaves in the same cycle.
  always_comb begin
    frame_s  = {asm_q, pipe_in_data};
    push_s   = pipe_in_valid && !flush && (idx_q == LAST_IDX);
    pop_s    = (cnt_q != {FW{1'b0}}) && frame_ready;
    accept_s = push_s && ((cnt_q < DEPTH_C) || pop_s);
    drop_s   = push_s && !accept_s;
  end

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (flush) begin
      idx_d = 2'd0;
      asm_d = {96{1'b0}};
    end else if (pipe_in_valid) begin
      case (idx_q)
        2'd0:    asm_d[95:64] = pipe_in_data;
        2'd1:    asm_d[63:32] = pipe_in_data;
        2'd2:    asm_d[31:0]  = pipe_in_data;
        default: asm_d        = {96{1'b0}};
      endcase
      idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  always_comb begin
    wr_ptr_d = accept_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // A drop in the clearing cycle survives the clear as the first new drop.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_ovf) begin
      ovf_d  = drop_s;
      drop_d = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      idx_q    <= 2'd0;
      asm_q    <= {96{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {FW{1'b0}};
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {128{1'b0}};
      end
    end else begin
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      if (accept_s) begin
        mem_q[wr_ptr_q] <= frame_s;
      end
    end
  end

  // Outputs decode registered state only; the head is masked while empty.
  always_comb begin
    frame_valid = (cnt_q != {FW{1'b0}});
    fill_level  = cnt_q;
    frame_data  = frame_valid ? mem_q[rd_ptr_q] : {128{1'b0}};
    overflow    = ovf_q;
    drop_count  = drop_q;
  end
endmodule
